// File: rtl/res_tx.sv
`timescale 1ns/1ps
// Result readout: streams NBYTES bytes from the result buffer to the Raspberry Pi
// over GPIO, one byte per Pi acknowledge strobe.
module res_tx #(
  parameter int WD     = 8,
  parameter int NBYTES = 10,
  parameter int AW     = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          igo,
  input  logic          rpi_en,
  input  logic [WD-1:0] rd_data,
  output logic          rd_cen_n,
  output logic [AW-1:0] rd_addr,
  output logic [WD-1:0] io_out,
  output logic          io_oe,
  output logic          io_vld,
  output logic          rpi_req,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(NBYTES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] idx;
  logic          igo_q;
  logic          start;
  logic          en_q;
  logic          ack;

  // Input edge detect: a held level yields exactly one registered pulse
  always_ff @(posedge clk) begin
    if (!rstn) begin
      igo_q <= 1'b0;
      start <= 1'b0;
      en_q  <= 1'b0;
      ack   <= 1'b0;
    end else begin
      igo_q <= igo;
      start <= igo & ~igo_q;
      en_q  <= rpi_en;
      ack   <= rpi_en & ~en_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = LOAD;
      LOAD:    state_nxt = WAIT;
      WAIT:    if (ack) state_nxt = (idx == LAST) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered GPIO-side outputs; io_out only changes while io_vld is low
  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx     <= '0;
      io_out  <= '0;
      io_vld  <= 1'b0;
      io_oe   <= 1'b0;
      rpi_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx     <= '0;
            busy    <= 1'b1;
            io_oe   <= 1'b1;
            rpi_req <= 1'b1;
          end
        end
        FETCH: ;
        LOAD: begin
          io_out <= rd_data;
          io_vld <= 1'b1;
        end
        WAIT: begin
          if (ack) begin
            io_vld <= 1'b0;
            if (idx == LAST) begin
              rpi_req <= 1'b0;
              io_oe   <= 1'b0;
              io_out  <= '0;
              done    <= 1'b1;
              idx     <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The buffer read is issued only in FETCH; the address simply tracks idx
  assign rd_cen_n = (state != FETCH);
  assign rd_addr  = idx;

endmodule

// File: tb/tb_res_tx.sv
`timescale 1ns/1ps
// Bench for res_tx: registered-read result buffer model, Pi strobe driver and
// an output-byte scoreboard; a second instance covers the single-byte case.
module tb_res_tx;
  localparam int WD = 8;
  localparam int NB = 10;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, igo, rpi_en;
  logic [WD-1:0] rd_data;
  logic          rd_cen_n;
  logic [AW-1:0] rd_addr;
  logic [WD-1:0] io_out;
  logic          io_oe, io_vld, rpi_req, busy, done;

  logic          igo1, rpi_en1;
  logic [WD-1:0] rd_data1;
  logic          rd_cen_n1;
  logic [AW-1:0] rd_addr1;
  logic [WD-1:0] io_out1;
  logic          io_oe1, io_vld1, rpi_req1, busy1, done1;

  logic [WD-1:0] mem  [2**AW];
  logic [WD-1:0] mem1 [2**AW];

  res_tx #(.WD(WD), .NBYTES(NB), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .igo(igo), .rpi_en(rpi_en), .rd_data(rd_data),
    .rd_cen_n(rd_cen_n), .rd_addr(rd_addr), .io_out(io_out), .io_oe(io_oe),
    .io_vld(io_vld), .rpi_req(rpi_req), .busy(busy), .done(done));

  res_tx #(.WD(WD), .NBYTES(1), .AW(AW)) dut1 (
    .clk(clk), .rstn(rstn), .igo(igo1), .rpi_en(rpi_en1), .rd_data(rd_data1),
    .rd_cen_n(rd_cen_n1), .rd_addr(rd_addr1), .io_out(io_out1), .io_oe(io_oe1),
    .io_vld(io_vld1), .rpi_req(rpi_req1), .busy(busy1), .done(done1));

  // Result buffer: data appears the cycle after a read-enabled edge
  always @(posedge clk) begin
    if (rd_cen_n === 1'b0)  rd_data  <= mem[rd_addr];
    if (rd_cen_n1 === 1'b0) rd_data1 <= mem1[rd_addr1];
  end

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [WD-1:0] exp_q  [$];
  logic [WD-1:0] obs_q  [$];
  logic [AW-1:0] addr_q [$];
  int            done_cnt = 0;
  int            unstable = 0;
  logic          vld_d    = 1'b0;
  logic [WD-1:0] last_out = '0;

  // Monitor: records presented bytes, issued read addresses and done pulses
  always @(negedge clk) begin
    if (io_vld === 1'b1 && vld_d !== 1'b1) obs_q.push_back(io_out);
    if (io_vld === 1'b1 && vld_d === 1'b1 && io_out !== last_out) unstable <= unstable + 1;
    if (rd_cen_n === 1'b0) addr_q.push_back(rd_addr);
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    vld_d    <= io_vld;
    last_out <= io_out;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_expected();
    exp_q.delete();
    for (int i = 0; i < NB; i++) exp_q.push_back(WD'(8'hA0 + i));
  endtask

  task automatic pi_serve(input int n, input int dly, output bit ok);
    int t;
    ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (io_vld !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      if (io_vld !== 1'b1) begin ok = 1'b0; return; end
      repeat (dly) @(negedge clk);
      rpi_en = 1'b1;
      repeat (2) @(negedge clk);
      rpi_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    bit ok;
    int d0, t;
    rstn = 1'b0; igo = 1'b1; rpi_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (io_out !== '0)    begin n_fail++; $display("FAIL rst_io_out: got %0h want 0", io_out); end
    n_checks++; if (io_vld !== 1'b0)  begin n_fail++; $display("FAIL rst_io_vld: got %b want 0", io_vld); end
    n_checks++; if (rpi_req !== 1'b0) begin n_fail++; $display("FAIL rst_rpi_req: got %b want 0", rpi_req); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_checks++; if (rd_cen_n !== 1'b1) begin n_fail++; $display("FAIL rst_rd_cen_n: got %b want 1", rd_cen_n); end
    n_checks++; if (io_oe !== 1'b0)   begin n_fail++; $display("FAIL rst_io_oe: got %b want 0", io_oe); end
    obs_q.delete(); addr_q.delete(); push_expected(); d0 = done_cnt;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    rpi_en = 1'b0;
    pi_serve(NB, 5, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_serve: got timeout want %0d bytes", NB); end
    t = 0;
    while (done_cnt == d0 && t < 100) begin @(negedge clk); t++; end
    igo = 1'b0;
    repeat (10) @(negedge clk); #1;
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL rst_held_igo_done: got %0d want 1", done_cnt - d0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_after: got %b want 0", busy); end
    n_checks++; if (obs_q.size() != NB) begin n_fail++; $display("FAIL rst_nbytes: got %0d want %0d", obs_q.size(), NB); end
    for (int i = 0; i < NB && i < obs_q.size(); i++) begin
      logic [WD-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (obs_q[i] !== e) begin n_fail++; $display("FAIL rst_byte%0d: got %0h want %0h", i, obs_q[i], e); end
    end
  endtask

  task automatic test_full();
    bit ok;
    int d0, t;
    @(negedge clk);
    obs_q.delete(); addr_q.delete(); push_expected(); d0 = done_cnt;
    @(posedge clk); #1 igo = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (io_vld !== 1'b0) begin n_fail++; $display("FAIL lat_early: got %b want 0", io_vld); end
    @(negedge clk);
    n_checks++; if (io_vld !== 1'b1) begin n_fail++; $display("FAIL lat_first: got %b want 1", io_vld); end
    igo = 1'b0;
    pi_serve(NB - 1, 20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_serve: got timeout want %0d bytes", NB - 1); end
    t = 0;
    while (io_vld !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    repeat (20) @(negedge clk);
    rpi_en = 1'b1;
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || rpi_req !== 1'b1) begin n_fail++; $display("FAIL done_edge1: got done=%b req=%b want done=0 req=1", done, rpi_req); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || rpi_req !== 1'b0) begin n_fail++; $display("FAIL done_edge2: got done=%b req=%b want done=1 req=0", done, rpi_req); end
    rpi_en = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL done_edge3: got done=%b busy=%b want 0 0", done, busy); end
    @(negedge clk); #1;
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt - d0); end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL full_stable: got %0d changes want 0", unstable); end
    n_checks++; if (addr_q.size() != NB) begin n_fail++; $display("FAIL full_nreads: got %0d want %0d", addr_q.size(), NB); end
    for (int i = 0; i < NB && i < addr_q.size(); i++) begin
      n_checks++; if (addr_q[i] !== AW'(i)) begin n_fail++; $display("FAIL full_addr%0d: got %0d want %0d", i, addr_q[i], i); end
    end
    n_checks++; if (obs_q.size() != NB) begin n_fail++; $display("FAIL full_nbytes: got %0d want %0d", obs_q.size(), NB); end
    for (int i = 0; i < NB && i < obs_q.size(); i++) begin
      logic [WD-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (obs_q[i] !== e) begin n_fail++; $display("FAIL full_byte%0d: got %0h want %0h", i, obs_q[i], e); end
    end
  endtask

  task automatic test_retrigger();
    bit ok;
    int d0, t;
    @(negedge clk);
    obs_q.delete(); addr_q.delete(); push_expected(); d0 = done_cnt;
    igo = 1'b1; repeat (2) @(negedge clk); igo = 1'b0;
    pi_serve(4, 8, ok);
    t = 0;
    while (io_vld !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    igo = 1'b1; repeat (2) @(negedge clk); igo = 1'b0;
    n_checks++; if (!ok || io_out !== 8'hA4) begin n_fail++; $display("FAIL retrig_byte4: got ok=%b %0h want 1 a4", ok, io_out); end
    pi_serve(6, 8, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL retrig_serve: got timeout want 6 bytes"); end
    repeat (30) @(negedge clk); #1;
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL retrig_done_cnt: got %0d want 1", done_cnt - d0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL retrig_not_queued: got busy=%b want 0", busy); end
    n_checks++; if (obs_q.size() != NB) begin n_fail++; $display("FAIL retrig_nbytes: got %0d want %0d", obs_q.size(), NB); end
    for (int i = 0; i < NB && i < obs_q.size(); i++) begin
      logic [WD-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (obs_q[i] !== e) begin n_fail++; $display("FAIL retrig_byte%0d: got %0h want %0h", i, obs_q[i], e); end
    end
  endtask

  task automatic test_spurious_ack();
    bit ok;
    int d0;
    @(negedge clk);
    obs_q.delete(); addr_q.delete(); push_expected(); d0 = done_cnt;
    @(posedge clk); #1 igo = 1'b1;
    repeat (2) @(posedge clk);
    #1 rpi_en = 1'b1;
    n_checks++; if (rd_cen_n !== 1'b0) begin n_fail++; $display("FAIL spur_in_fetch: got rd_cen_n=%b want 0", rd_cen_n); end
    repeat (2) @(posedge clk);
    #1 rpi_en = 1'b0; igo = 1'b0;
    repeat (10) @(negedge clk); #1;
    n_checks++; if (io_vld !== 1'b1 || obs_q.size() != 1) begin n_fail++; $display("FAIL spur_ignored: got vld=%b n=%0d want 1 1", io_vld, obs_q.size()); end
    @(negedge clk);
    rpi_en = 1'b1;
    repeat (50) @(negedge clk); #1;
    n_checks++; if (obs_q.size() != 2 || io_vld !== 1'b1 || io_out !== 8'hA1) begin
      n_fail++; $display("FAIL held_ack: got n=%0d vld=%b %0h want 2 1 a1", obs_q.size(), io_vld, io_out);
    end
    @(negedge clk);
    rpi_en = 1'b0;
    pi_serve(NB - 1, 5, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL spur_serve: got timeout want %0d bytes", NB - 1); end
    repeat (10) @(negedge clk); #1;
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL spur_done_cnt: got %0d want 1", done_cnt - d0); end
    for (int i = 0; i < NB && i < obs_q.size(); i++) begin
      logic [WD-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (obs_q[i] !== e) begin n_fail++; $display("FAIL spur_byte%0d: got %0h want %0h", i, obs_q[i], e); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0;
    @(negedge clk);
    obs_q.delete(); addr_q.delete();
    igo = 1'b1; repeat (2) @(negedge clk); igo = 1'b0;
    pi_serve(5, 5, ok);
    d0 = done_cnt;
    rstn = 1'b0;
    @(negedge clk);
    n_checks++; if (rpi_req !== 1'b0 || busy !== 1'b0 || io_vld !== 1'b0 || io_oe !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_ctrl: got req=%b busy=%b vld=%b oe=%b want 0000", rpi_req, busy, io_vld, io_oe);
    end
    n_checks++; if (io_out !== '0 || rd_cen_n !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_data: got out=%0h cen_n=%b done=%b want 0 1 0", io_out, rd_cen_n, done);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk); #1;
    obs_q.delete(); addr_q.delete(); push_expected();
    igo = 1'b1; repeat (2) @(negedge clk); igo = 1'b0;
    pi_serve(NB, 5, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_serve: got timeout want %0d bytes", NB); end
    repeat (10) @(negedge clk); #1;
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL mid_done_cnt: got %0d want 1", done_cnt - d0); end
    n_checks++; if (addr_q.size() == 0 || addr_q[0] !== '0) begin n_fail++; $display("FAIL mid_first_addr: got n=%0d want addr 0", addr_q.size()); end
    for (int i = 0; i < NB && i < obs_q.size(); i++) begin
      logic [WD-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (obs_q[i] !== e) begin n_fail++; $display("FAIL mid_byte%0d: got %0h want %0h", i, obs_q[i], e); end
    end
  endtask

  task automatic test_single_byte();
    logic [WD-1:0] exp1_q [$];
    logic [WD-1:0] e;
    int t;
    @(negedge clk);
    exp1_q.push_back(8'h5C);
    igo1 = 1'b1; repeat (2) @(negedge clk); igo1 = 1'b0;
    t = 0;
    while (io_vld1 !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    e = exp1_q.pop_front();
    n_checks++; if (io_vld1 !== 1'b1 || io_out1 !== e) begin n_fail++; $display("FAIL nb1_byte: got vld=%b %0h want 1 %0h", io_vld1, io_out1, e); end
    n_checks++; if (rpi_req1 !== 1'b1 || io_oe1 !== 1'b1) begin n_fail++; $display("FAIL nb1_req: got req=%b oe=%b want 1 1", rpi_req1, io_oe1); end
    repeat (3) @(negedge clk);
    rpi_en1 = 1'b1;
    @(negedge clk);
    n_checks++; if (done1 !== 1'b0 || rpi_req1 !== 1'b1) begin n_fail++; $display("FAIL nb1_edge1: got done=%b req=%b want 0 1", done1, rpi_req1); end
    @(negedge clk);
    n_checks++; if (done1 !== 1'b1 || rpi_req1 !== 1'b0 || io_oe1 !== 1'b0) begin
      n_fail++; $display("FAIL nb1_edge2: got done=%b req=%b oe=%b want 1 0 0", done1, rpi_req1, io_oe1);
    end
    rpi_en1 = 1'b0;
    @(negedge clk);
    n_checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL nb1_edge3: got done=%b busy=%b want 0 0", done1, busy1); end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]  = WD'(8'hA0 + i);
      mem1[i] = 8'h00;
    end
    mem1[0] = 8'h5C;
    igo1 = 1'b0; rpi_en1 = 1'b0;
    test_reset();
    test_full();
    test_retrigger();
    test_spurious_ack();
    test_reset_mid();
    test_single_byte();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
